// File: rtl/uart_reg_ctrl.sv
// rtl/uart_reg_ctrl.sv - CPU request/response controller decoding word addresses into register strobes
module uart_reg_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    input  logic                           req_we_i,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    input  logic [DATA_WIDTH-1:0]          req_wdata_i,
    output logic                           req_ready_o,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic [NUM_REGS-1:0]            reg_wr_en_o,
    output logic [NUM_REGS-1:0]            reg_rd_en_o,
    output logic [DATA_WIDTH-1:0]          reg_wdata_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [NUM_REGS-1:0]    sel;
    logic [DATA_WIDTH-1:0]  rd_mux;
    logic                   in_range;

    // Full-width compare so out-of-range addresses never alias onto a real register.
    assign in_range = ({1'b0, req_addr_i} < NUM_REGS_W);

    // Decode uses only the latched address, keeping req_* off the strobe paths.
    always_comb begin
        sel    = '0;
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == ADDR_WIDTH'(k)) begin
                sel[k] = 1'b1;
                rd_mux = reg_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        reg_wr_en_o = '0;
        reg_rd_en_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = !in_range;
                    state_d = in_range ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // Capture on the strobe edge so read-clear bits report their pre-clear value.
                if (we_q) begin
                    reg_wr_en_o = sel;
                    rdata_d     = '0;
                end else begin
                    reg_rd_en_o = sel;
                    rdata_d     = rd_mux;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb/tb_uart_reg_ctrl.sv - self-checking bench for uart_reg_ctrl
module tb_uart_reg_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         req_we_i;
    logic [2:0]   req_addr_i;
    logic [31:0]  req_wdata_i;
    logic         req_ready_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_err_o;
    logic [3:0]   reg_wr_en_o;
    logic [3:0]   reg_rd_en_o;
    logic [31:0]  reg_wdata_o;
    logic [127:0] reg_rdata_i;

    int checks = 0;
    int errors = 0;

    uart_reg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .NUM_REGS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .reg_wr_en_o(reg_wr_en_o), .reg_rd_en_o(reg_rd_en_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] regval;
        logic [3:0]  exp_wr;
        logic [3:0]  exp_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the controller idle; checks one full transaction.
    task automatic run_txn(input string name, input logic we, input logic [2:0] addr,
                           input logic [31:0] wdata, input logic [31:0] regval,
                           input logic [3:0] exp_wr, input logic [3:0] exp_rd,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [3:0]  wr_seen, rd_seen;
        logic [31:0] rdata, wd;
        logic        err, multi, pend_clear;
        int          nstrobe, strobe_cyc, lat;
        req_i       = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) reg_rdata_i[k*32 +: 32] = $urandom;
        if (addr < 3'd4) reg_rdata_i[int'(addr)*32 +: 32] = regval;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        wr_seen = '0; rd_seen = '0; multi = 1'b0; pend_clear = 1'b0;
        nstrobe = 0; strobe_cyc = 0; lat = 0; rdata = '0; wd = '0; err = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (c > 1) @(negedge clk_i);
            if (pend_clear) begin
                reg_rdata_i[int'(addr)*32 +: 32] = '0;
                pend_clear = 1'b0;
            end
            if ((reg_wr_en_o | reg_rd_en_o) != 4'b0) begin
                nstrobe++;
                strobe_cyc = c;
                if ($countones(reg_wr_en_o | reg_rd_en_o) > 1) multi = 1'b1;
                wr_seen |= reg_wr_en_o;
                rd_seen |= reg_rd_en_o;
                if (reg_rd_en_o != 4'b0) pend_clear = 1'b1;
            end
            if (rsp_valid_o) begin
                lat   = c;
                rdata = rsp_rdata_o;
                err   = rsp_err_o;
                wd    = reg_wdata_o;
            end
        end
        if (lat == 0) check({name, "_timeout"}, 0, 1);
        check({name, "_wr"}, wr_seen, exp_wr);
        check({name, "_rd"}, rd_seen, exp_rd);
        check({name, "_nstrobe"}, nstrobe, ((exp_wr | exp_rd) != 0) ? 1 : 0);
        check({name, "_strobe_cyc"}, strobe_cyc, ((exp_wr | exp_rd) != 0) ? 1 : 0);
        check({name, "_onehot"}, multi, 0);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_rdata"}, rdata, exp_rdata);
        check({name, "_err"}, err, exp_err);
        check({name, "_wdata"}, wd, wdata);
        @(posedge clk_i);
        @(negedge clk_i);
        check({name, "_idle"}, {req_ready_o, rsp_valid_o}, 2'b10);
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0]  m_wr, m_rd;
        logic [31:0] m_rdata, rv, wv;
        logic [2:0]  a;
        logic        w, inr;
        int          idx, nstr, nresp, last;
        logic [31:0] held;

        vecs[0] = '{1'b1, 3'd2, 32'hA5A5_0001, 32'h0,         4'b0100, 4'b0000, 32'h0,         1'b0, 2};
        vecs[1] = '{1'b0, 3'd2, 32'h0,         32'hA5A5_0001, 4'b0000, 4'b0100, 32'hA5A5_0001, 1'b0, 2};
        vecs[2] = '{1'b0, 3'd1, 32'h0,         32'h0000_0080, 4'b0000, 4'b0010, 32'h0000_0080, 1'b0, 2};
        vecs[3] = '{1'b0, 3'd5, 32'h0,         32'h1111_2222, 4'b0000, 4'b0000, 32'h0,         1'b1, 1};
        vecs[4] = '{1'b1, 3'd7, 32'hCAFE_F00D, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, 1};
        vecs[5] = '{1'b1, 3'd4, 32'h1234_0004, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, 1};
        vecs[6] = '{1'b0, 3'd3, 32'h0,         32'hDEAD_BEEF, 4'b0000, 4'b1000, 32'hDEAD_BEEF, 1'b0, 2};
        vecs[7] = '{1'b1, 3'd0, 32'h0BAD_CAFE, 32'h0,         4'b0001, 4'b0000, 32'h0,         1'b0, 2};

        // Reset with a request presented: nothing may be accepted.
        rst_i = 1'b1; req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd0;
        req_wdata_i = 32'hFFFF_FFFF; rsp_ready_i = 1'b1; reg_rdata_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_ready", req_ready_o, 1);
        check("reset_valid", rsp_valid_o, 0);
        check("reset_rdata", rsp_rdata_o, 0);
        check("reset_err", rsp_err_o, 0);
        check("reset_strobes", {reg_wr_en_o, reg_rd_en_o}, 0);
        check("reset_wdata", reg_wdata_o, 0);
        req_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].regval,
                    vecs[i].exp_wr, vecs[i].exp_rd, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);

        // Random transactions against the address-rule model.
        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom);
            a   = 3'($urandom_range(0, 7));
            wv  = $urandom;
            rv  = $urandom;
            inr = (a < 3'd4);
            m_wr    = (inr && w)  ? (4'b0001 << a) : 4'b0000;
            m_rd    = (inr && !w) ? (4'b0001 << a) : 4'b0000;
            m_rdata = (inr && !w) ? rv : 32'h0;
            run_txn($sformatf("rand%0d", i), w, a, wv, rv, m_wr, m_rd, m_rdata, !inr, inr ? 2 : 1);
        end

        // Backpressure: response held, second request refused, then accepted after release.
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd3; rsp_ready_i = 1'b0;
        reg_rdata_i[3*32 +: 32] = 32'h1234_5678;
        @(posedge clk_i);
        @(negedge clk_i);
        req_we_i = 1'b1; req_addr_i = 3'd0; req_wdata_i = 32'h5555_AAAA;
        check("bp_rd_strobe", reg_rd_en_o, 4'b1000);
        @(negedge clk_i);
        reg_rdata_i[3*32 +: 32] = 32'h0;
        held = rsp_rdata_o;
        check("bp_rdata", held, 32'h1234_5678);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("bp_hold", {rsp_valid_o, req_ready_o, reg_wr_en_o, reg_rd_en_o, rsp_rdata_o},
                  {1'b1, 1'b0, 8'h00, held});
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_idle", {req_ready_o, rsp_valid_o}, 2'b10);
        @(negedge clk_i);
        req_i = 1'b0;
        check("bp_second_strobe", reg_wr_en_o, 4'b0001);
        check("bp_second_wdata", reg_wdata_o, 32'h5555_AAAA);
        @(negedge clk_i);
        check("bp_second_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
        @(negedge clk_i);

        // Back-to-back writes to 0..3 with req_i and rsp_ready_i held high.
        idx = 0; nstr = 0; nresp = 0; last = 0;
        for (int c = 0; c < 20; c++) begin
            if ((reg_wr_en_o | reg_rd_en_o) != 4'b0) begin
                check("b2b_strobe", {reg_wr_en_o, reg_rd_en_o}, {4'b0001 << nstr, 4'b0000});
                if (nstr > 0) check("b2b_gap", c - last, 3);
                last = c;
                nstr++;
            end
            if (rsp_valid_o) begin
                nresp++;
                check("b2b_err", rsp_err_o, 0);
            end
            if (req_ready_o && idx < 4) begin
                req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 3'(idx); req_wdata_i = $urandom;
                idx++;
            end else if (req_ready_o) begin
                req_i = 1'b0;
            end
            @(negedge clk_i);
        end
        req_i = 1'b0;
        check("b2b_nstrobe", nstr, 4);
        check("b2b_nresp", nresp, 4);

        // Asynchronous reset during ACCESS.
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd1; rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        check("rst_acc_pre", reg_rd_en_o, 4'b0010);
        #2 rst_i = 1'b1;
        #1 check("rst_acc_post", {reg_wr_en_o, reg_rd_en_o, rsp_valid_o, req_ready_o}, 10'b00000000_0_1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Asynchronous reset during RESP.
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd2; rsp_ready_i = 1'b0;
        reg_rdata_i[2*32 +: 32] = 32'h8765_4321;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i);
        #2 check("rst_resp_pre", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'h8765_4321});
        #1 rst_i = 1'b1;
        #1 check("rst_resp_post", {rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_err_o}, {2'b01, 32'h0, 1'b0});
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_txn("post_reset_read", 1'b0, 3'd0, 32'h0, 32'h0F0F_1234, 4'b0000, 4'b0001, 32'h0F0F_1234, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
Bus-side controller for the UART register bank. Accepts single CPU read/write requests over a valid/ready handshake and decodes the word address into one-cycle one-hot CPU write/read strobes for NUM_REGS register instances. It captures read data in the same cycle as the read strobe, so read-clear bits return their pre-clear value. It returns a response through a valid/ready channel, with an error flag for out-of-range addresses.

Parameters:
DATA_WIDTH, 32, width of each register and of the bus data.
ADDR_WIDTH, 3, width of the word address; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
NUM_REGS, 4, number of registers in the bank; valid addresses are 0..NUM_REGS-1.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous active-high reset.
req_i  input  1  CPU request valid.
req_we_i  input  1  request type: 1 = write, 0 = read.
req_addr_i  input  ADDR_WIDTH  word address.
req_wdata_i  input  DATA_WIDTH  write data.
req_ready_o  output  1  controller can accept a request.
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  CPU accepts response.
rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors.
rsp_err_o  output  1  1 = address out of range.
reg_wr_en_o  output  NUM_REGS  one-hot CPU write strobes to the registers.
reg_rd_en_o  output  NUM_REGS  one-hot CPU read strobes to the registers.
reg_wdata_o  output  DATA_WIDTH  write data to all registers.
reg_rdata_i  input  NUM_REGS*DATA_WIDTH  register outputs, flattened; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, and all latched address/we/wdata/rdata/err flops are cleared to 0.
  - Output values in reset: req_ready_o=1 (IDLE), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, reg_wr_en_o=0, reg_rd_en_o=0, reg_wdata_o=0.
  - Requests presented while rst_i=1 are not accepted.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - A handshake occurs on an edge with req_i=1 and req_ready_o=1. On that edge the controller latches addr, we and wdata.
  - If addr < NUM_REGS: go to ACCESS, err=0.
  - If addr >= NUM_REGS: go directly to RESP with err=1 and rdata=0. No strobe is issued.
- ACCESS (exactly 1 cycle):
  - If we=1: reg_wr_en_o[addr]=1.
  - If we=0: reg_rd_en_o[addr]=1, and the rdata flop captures reg_rdata_i slice addr at the closing edge, i.e. the pre-clear value.
  - For writes, rdata is cleared to 0.
  - Next state is RESP.
- RESP:
  - rsp_valid_o=1 and rsp_rdata_o/rsp_err_o are held stable until a handshake with rsp_ready_i=1; then go to IDLE.
  - rsp_ready_i may be low indefinitely; no strobes are issued while waiting.
- req_ready_o=0 in ACCESS and RESP. Only one transaction is outstanding at a time.
- Latency: request accepted at edge N → strobe active during cycle N+1 → rsp_valid_o=1 from edge N+2. The error path asserts rsp_valid_o from edge N+1.
  - Max throughput is 1 transaction per 3 cycles (2 for errors) with rsp_ready_i tied high.
- Strobes:
  - Decoded only from state and the latched address; no combinational path from req_* inputs.
  - At most one bit of reg_wr_en_o | reg_rd_en_o is set in any cycle.
  - Strobes are zero in IDLE and RESP.
- reg_wdata_o:
  - Driven from the latched wdata.
  - Stable from ACCESS through return to IDLE.
  - Changes only on a request handshake.
- Writes to read-only register bits are silently ignored by the register itself. The controller reports err=0 for any in-range address.
- The controller does not arbitrate peripheral writes: a concurrent peripheral write to the addressed register loses to the CPU strobe, per the register's fixed priority.
- Reset during ACCESS: the strobe deasserts immediately (asynchronously) and the in-flight response is dropped.
- Reset during RESP: rsp_valid_o drops immediately and the response is lost; no partial outputs survive.
- Address decode uses a full ADDR_WIDTH compare. Addresses never wrap modulo NUM_REGS.

Test Plan:
- Write then read: write addr=2, wdata=0xA5A5_0001 → reg_wr_en_o=4'b0100 for exactly 1 cycle at N+1, rsp_valid_o at N+2 with err=0, rdata=0. Then read addr=2 with reg_rdata_i slice 2=0xA5A5_0001 → reg_rd_en_o=4'b0100 for 1 cycle, rsp_rdata_o=0xA5A5_0001.
- Read-clear capture: register 1 outputs 0x0000_0080 during the strobe cycle and 0 afterwards → rsp_rdata_o=0x0000_0080.
- Out-of-range: read addr=5 (NUM_REGS=4) → no strobes, rsp_valid_o at N+1, rsp_err_o=1, rsp_rdata_o=0.
- Backpressure: rsp_ready_i=0 for 10 cycles → rsp_valid_o and rsp_rdata_o held stable, req_ready_o=0, a second request is not accepted, no extra strobes. Release → back in IDLE, and the second request is accepted on the next edge.
- Back-to-back: req_i and rsp_ready_i held high, 4 writes to addresses 0..3 → one strobe every 3 cycles, each one-hot and matching its address, 4 responses, none with err=1.
- Async reset in ACCESS and in RESP: assert rst_i mid-cycle → strobes and rsp_valid_o deassert before the next edge and req_ready_o=1. After release, a read of addr=0 completes normally with latency 2.
